// File: rtl/dvg_sequencer_if.sv
// dvg_sequencer_if
//   Bundles the display-list fetch port and the draw-unit handshake of the
//   DVG sequencer.
//   master : sequencer side  (drives fetch_req/fetch_addr, instr_hi/lo, draw_go)
//   slave  : memory + draw unit side (drives fetch_ack/fetch_data, draw_done)
//   fetch_req/fetch_addr/fetch_ack/fetch_data : word fetch handshake
//   instr_hi/instr_lo/draw_go/draw_done        : vector op hand-off to draw unit
interface dvg_sequencer_if #(
  parameter int AW = 12
);
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ack;
  logic [15:0]   fetch_data;
  logic [15:0]   instr_hi;
  logic [15:0]   instr_lo;
  logic          draw_go;
  logic          draw_done;

  modport master (
    output fetch_req, fetch_addr, instr_hi, instr_lo, draw_go,
    input  fetch_ack, fetch_data, draw_done
  );

  modport slave (
    input  fetch_req, fetch_addr, instr_hi, instr_lo, draw_go,
    output fetch_ack, fetch_data, draw_done
  );
endinterface

// File: rtl/dvg_sequencer.sv
// dvg_sequencer
//   Display-list sequencer: fetches 1/2-word instructions, runs JMPL/JSRL/RTSL
//   against an internal return stack, hands vector ops to the draw unit, and
//   guards every wait with a watchdog. Errors are sticky until the next start.
//   clk, reset_n       : clock / asynchronous active-low reset
//   start, start_addr  : 1-cycle run request and first instruction address
//   stop               : abort the running list, go back to IDLE
//   bus (master)       : fetch port and draw handshake (see dvg_sequencer_if)
//   blank, halted      : beam blank (low only while drawing), idle/error flag
//   stack_ptr          : return-stack occupancy 0..SD
//   err_*              : sticky overflow / underflow / watchdog errors
module dvg_sequencer #(
  parameter int AW      = 12,
  parameter int SD      = 4,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          stop,
  dvg_sequencer_if.master bus,
  output logic          blank,
  output logic          halted,
  output logic [4:0]    stack_ptr,
  output logic          err_overflow,
  output logic          err_underflow,
  output logic          err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_HI  = 3'd1,
    S_FETCH_LO  = 3'd2,
    S_EXEC      = 3'd3,
    S_DRAW_WAIT = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  // Last waiting cycle that may still be rescued by ack/done.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [4:0]      SD_FULL = 5'(SD);

  // Opcodes 0-A carry a second word.
  function automatic logic is_two_word(input logic [3:0] op);
    return (op <= 4'hA);
  endfunction

  // Vector ops handed to the draw unit: VCTR, LABS, SVEC.
  function automatic logic is_draw(input logic [3:0] op);
    return (op <= 4'hA) || (op == 4'hF);
  endfunction

  state_t          state_r, state_s;
  logic [AW-1:0]   pc_r, pc_s;
  logic [4:0]      sp_r, sp_s;
  logic [15:0]     hi_r, hi_s, lo_r, lo_s;
  logic [TO_W-1:0] wd_r, wd_s, wd_inc_s;
  logic            ovf_r, ovf_s, unf_r, unf_s, tmo_r, tmo_s;
  logic            fetch_req_r, draw_go_r, blank_r, halted_r;
  logic            push_s;
  logic [3:0]      pop_idx_s;
  // Sized for the maximum depth; only entries below SD are ever touched.
  logic [AW-1:0]   stack_r [0:15];

  // Next-state, datapath and watchdog decision for the current state.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    sp_s      = sp_r;
    hi_s      = hi_r;
    lo_s      = lo_r;
    ovf_s     = ovf_r;
    unf_s     = unf_r;
    tmo_s     = tmo_r;
    wd_inc_s  = wd_r;
    push_s    = 1'b0;
    // sp[3:0]-1 also yields 15 when sp==16, so the top of a full 16-deep stack is reachable.
    pop_idx_s = sp_r[3:0] - 4'd1;

    if (stop && (state_r != S_IDLE)) begin
      state_s = S_IDLE;
    end else if (start && ((state_r == S_IDLE) || (state_r == S_ERROR))) begin
      pc_s    = start_addr;
      sp_s    = 5'd0;
      ovf_s   = 1'b0;
      unf_s   = 1'b0;
      tmo_s   = 1'b0;
      state_s = S_FETCH_HI;
    end else begin
      case (state_r)
        S_FETCH_HI: begin
          if (bus.fetch_ack) begin
            hi_s    = bus.fetch_data;
            pc_s    = pc_r + 1'b1;
            state_s = is_two_word(bus.fetch_data[15:12]) ? S_FETCH_LO : S_EXEC;
          end else if (wd_r == WD_LAST) begin
            tmo_s   = 1'b1;
            state_s = S_ERROR;
          end else begin
            wd_inc_s = wd_r + 1'b1;
          end
        end
        S_FETCH_LO: begin
          if (bus.fetch_ack) begin
            lo_s    = bus.fetch_data;
            pc_s    = pc_r + 1'b1;
            state_s = S_EXEC;
          end else if (wd_r == WD_LAST) begin
            tmo_s   = 1'b1;
            state_s = S_ERROR;
          end else begin
            wd_inc_s = wd_r + 1'b1;
          end
        end
        S_EXEC: begin
          if (is_draw(hi_r[15:12])) begin
            state_s = S_DRAW_WAIT;
          end else begin
            case (hi_r[15:12])
              4'hB: state_s = S_IDLE;
              4'hC: begin
                if (sp_r == SD_FULL) begin
                  ovf_s   = 1'b1;
                  state_s = S_ERROR;
                end else begin
                  push_s  = 1'b1;
                  sp_s    = sp_r + 5'd1;
                  pc_s    = hi_r[AW-1:0];
                  state_s = S_FETCH_HI;
                end
              end
              4'hD: begin
                if (sp_r == 5'd0) begin
                  unf_s   = 1'b1;
                  state_s = S_ERROR;
                end else begin
                  sp_s    = sp_r - 5'd1;
                  pc_s    = stack_r[pop_idx_s];
                  state_s = S_FETCH_HI;
                end
              end
              4'hE: begin
                pc_s    = hi_r[AW-1:0];
                state_s = S_FETCH_HI;
              end
              default: state_s = S_IDLE;
            endcase
          end
        end
        S_DRAW_WAIT: begin
          if (bus.draw_done) begin
            state_s = S_FETCH_HI;
          end else if (wd_r == WD_LAST) begin
            tmo_s   = 1'b1;
            state_s = S_ERROR;
          end else begin
            wd_inc_s = wd_r + 1'b1;
          end
        end
        S_IDLE:  state_s = S_IDLE;
        S_ERROR: state_s = S_ERROR;
        default: state_s = S_IDLE;
      endcase
    end

    // Every state change lands in a fresh wait (or a state that ignores the
    // counter), so clearing on any change implements "clear on entry".
    wd_s = (state_s != state_r) ? '0 : wd_inc_s;
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      pc_r        <= '0;
      sp_r        <= 5'd0;
      hi_r        <= 16'h0000;
      lo_r        <= 16'h0000;
      wd_r        <= '0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      tmo_r       <= 1'b0;
      fetch_req_r <= 1'b0;
      draw_go_r   <= 1'b0;
      blank_r     <= 1'b1;
      halted_r    <= 1'b1;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      sp_r        <= sp_s;
      hi_r        <= hi_s;
      lo_r        <= lo_s;
      wd_r        <= wd_s;
      ovf_r       <= ovf_s;
      unf_r       <= unf_s;
      tmo_r       <= tmo_s;
      fetch_req_r <= (state_s == S_FETCH_HI) || (state_s == S_FETCH_LO);
      draw_go_r   <= (state_s == S_EXEC) && is_draw(hi_s[15:12]);
      blank_r     <= (state_s != S_DRAW_WAIT);
      halted_r    <= (state_s == S_IDLE) || (state_s == S_ERROR);
    end
  end

  // Return-stack storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_r[sp_r[3:0]] <= pc_r;
    end
  end

  assign bus.fetch_req  = fetch_req_r;
  assign bus.fetch_addr = pc_r;
  assign bus.instr_hi   = hi_r;
  assign bus.instr_lo   = lo_r;
  assign bus.draw_go    = draw_go_r;
  assign blank          = blank_r;
  assign halted         = halted_r;
  assign stack_ptr      = sp_r;
  assign err_overflow   = ovf_r;
  assign err_underflow  = unf_r;
  assign err_timeout    = tmo_r;

endmodule

// File: tb/tb_dvg_sequencer.sv
// tb_dvg_sequencer
//   Directed bench for dvg_sequencer (AW=12, SD=4, TIMEOUT=16). A memory model
//   acks every request in the same cycle; draw_done is driven by the sequence.
module tb_dvg_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] start_addr = 12'h000;
  logic        stop = 1'b0;
  logic        blank, halted, err_overflow, err_underflow, err_timeout;
  logic [4:0]  stack_ptr;
  logic [15:0] mem [0:4095];
  int          n_total = 0;
  int          n_pass = 0;
  int          go_cnt = 0;
  int          blank_cnt = 0;
  int          go0, blank0;

  dvg_sequencer_if #(.AW(12)) bus ();

  dvg_sequencer #(.AW(12), .SD(4), .TO_W(8), .TIMEOUT(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .start_addr    (start_addr),
    .stop          (stop),
    .bus           (bus.master),
    .blank         (blank),
    .halted        (halted),
    .stack_ptr     (stack_ptr),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  assign bus.fetch_ack  = bus.fetch_req;
  assign bus.fetch_data = mem[bus.fetch_addr];

  always @(posedge clk) begin
    if (bus.draw_go) go_cnt <= go_cnt + 1;
    if (!blank) blank_cnt <= blank_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_start(input logic [11:0] addr);
    start_addr = addr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halted(input string tag);
    int i = 0;
    while (!halted && i < 200) begin
      tick();
      i++;
    end
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    bus.draw_done = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_blank", {31'd0, blank}, 32'd1);
    check("rst_req", {31'd0, bus.fetch_req}, 32'd0);
    check("rst_hi", {16'd0, bus.instr_hi}, 32'h0);
    check("rst_sp", {27'd0, stack_ptr}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: single HALT at 0x010
    mem[12'h010] = 16'hB000;
    go0 = go_cnt;
    pulse_start(12'h010);
    check("t1_req", {31'd0, bus.fetch_req}, 32'd1);
    check("t1_addr", {20'd0, bus.fetch_addr}, 32'h010);
    tick();
    check("t1_hi", {16'd0, bus.instr_hi}, 32'hB000);
    check("t1_busy", {31'd0, halted}, 32'd0);
    tick();
    check("t1_halted", {31'd0, halted}, 32'd1);
    check("t1_no_go", go_cnt - go0, 32'd0);

    // 2: two-word VCTR, draw_done 5 cycles after go
    mem[12'h000] = 16'h9123;
    mem[12'h001] = 16'h4456;
    mem[12'h002] = 16'hB000;
    go0 = go_cnt;
    blank0 = blank_cnt;
    pulse_start(12'h000);
    tick();
    check("t2_lo_addr", {20'd0, bus.fetch_addr}, 32'h001);
    tick();
    check("t2_go", {31'd0, bus.draw_go}, 32'd1);
    check("t2_hi", {16'd0, bus.instr_hi}, 32'h9123);
    check("t2_lo", {16'd0, bus.instr_lo}, 32'h4456);
    tick();
    for (int i = 1; i <= 5; i++) begin
      check("t2_blank_low", {31'd0, blank}, 32'd0);
      if (i == 5) bus.draw_done = 1'b1;
      tick();
    end
    bus.draw_done = 1'b0;
    check("t2_blank_back", {31'd0, blank}, 32'd1);
    check("t2_next_addr", {20'd0, bus.fetch_addr}, 32'h002);
    wait_halted("t2_halt");
    check("t2_go_cnt", go_cnt - go0, 32'd1);
    check("t2_blank_cnt", blank_cnt - blank0, 32'd5);

    // 3: five nested JSRL with SD=4
    mem[12'h000] = 16'hC100;
    mem[12'h100] = 16'hC200;
    mem[12'h200] = 16'hC300;
    mem[12'h300] = 16'hC400;
    mem[12'h400] = 16'hC500;
    pulse_start(12'h000);
    wait_halted("t3_halt");
    check("t3_ovf", {31'd0, err_overflow}, 32'd1);
    check("t3_sp", {27'd0, stack_ptr}, 32'd4);
    check("t3_unf", {31'd0, err_underflow}, 32'd0);

    // 4: RTSL with empty stack, then JSRL/RTSL pair
    mem[12'h020] = 16'hD000;
    pulse_start(12'h020);
    wait_halted("t4_halt");
    check("t4_unf", {31'd0, err_underflow}, 32'd1);
    check("t4_ovf_cleared", {31'd0, err_overflow}, 32'd0);
    check("t4_sp", {27'd0, stack_ptr}, 32'd0);
    mem[12'h030] = 16'hC040;
    mem[12'h031] = 16'hB000;
    mem[12'h040] = 16'hD000;
    pulse_start(12'h030);
    check("t4_unf_cleared", {31'd0, err_underflow}, 32'd0);
    tick();
    tick();
    check("t4_call_addr", {20'd0, bus.fetch_addr}, 32'h040);
    check("t4_sp_push", {27'd0, stack_ptr}, 32'd1);
    tick();
    tick();
    check("t4_ret_addr", {20'd0, bus.fetch_addr}, 32'h031);
    check("t4_sp_pop", {27'd0, stack_ptr}, 32'd0);
    wait_halted("t4_halt2");
    check("t4_no_err", {29'd0, err_overflow, err_underflow, err_timeout}, 32'd0);

    // 5: watchdog in DRAW_WAIT, expiry then rescue on the last cycle
    mem[12'h050] = 16'hF000;
    mem[12'h051] = 16'hB000;
    pulse_start(12'h050);
    tick();
    check("t5_go", {31'd0, bus.draw_go}, 32'd1);
    tick();
    for (int i = 1; i <= 15; i++) tick();
    check("t5_no_tmo_yet", {31'd0, err_timeout}, 32'd0);
    check("t5_still_drawing", {31'd0, blank}, 32'd0);
    tick();
    check("t5_tmo", {31'd0, err_timeout}, 32'd1);
    check("t5_halted", {31'd0, halted}, 32'd1);
    pulse_start(12'h050);
    check("t5b_tmo_cleared", {31'd0, err_timeout}, 32'd0);
    tick();
    tick();
    for (int i = 1; i <= 15; i++) tick();
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
    check("t5b_no_tmo", {31'd0, err_timeout}, 32'd0);
    check("t5b_next_addr", {20'd0, bus.fetch_addr}, 32'h051);
    wait_halted("t5b_halt");
    check("t5b_no_tmo_end", {31'd0, err_timeout}, 32'd0);

    // 6: JMPL to 0xFFF, pc wrap, then stop with a pending ack
    mem[12'h060] = 16'hEFFF;
    mem[12'hFFF] = 16'hF000;
    mem[12'h000] = 16'h1234;
    pulse_start(12'h060);
    tick();
    tick();
    check("t6_jmp_addr", {20'd0, bus.fetch_addr}, 32'hFFF);
    tick();
    check("t6_svec_go", {31'd0, bus.draw_go}, 32'd1);
    tick();
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
    check("t6_wrap_addr", {20'd0, bus.fetch_addr}, 32'h000);
    check("t6_req", {31'd0, bus.fetch_req}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t6_stop_halted", {31'd0, halted}, 32'd1);
    check("t6_stop_req", {31'd0, bus.fetch_req}, 32'd0);
    check("t6_hi_kept", {16'd0, bus.instr_hi}, 32'hF000);
    tick();
    check("t6_idle_req", {31'd0, bus.fetch_req}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
